// File: rtl/cpu6_memstage_lsu_if.sv
// Data-bus port bundle between the memory-stage LSU (master) and the data bus (slave).
// Handshake: the master raises dbus_req with we/addr/wdata/wstrb and holds all of them stable
// until the slave returns a single-cycle dbus_ack; dbus_rdata is only meaningful in that ack cycle of a read.
interface cpu6_memstage_lsu_if #(parameter int XLEN = 32);
    logic            dbus_req;
    logic            dbus_we;
    logic [XLEN-1:0] dbus_addr;
    logic [XLEN-1:0] dbus_wdata;
    logic [3:0]      dbus_wstrb;
    logic            dbus_ack;
    logic [XLEN-1:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/cpu6_memstage_lsu.sv
// Memory-stage load/store unit: one outstanding data-bus access per instruction, with lane
// alignment, load extension, misalignment trap and bus-timeout trap.
module cpu6_memstage_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memwriteM,
    input  logic                memtoregM,
    input  logic [1:0]          lswidthM,
    input  logic                loadsignextM,
    input  logic [XLEN-1:0]     aluoutM,
    input  logic [XLEN-1:0]     writedataM,
    cpu6_memstage_lsu_if.master dbus,
    output logic                stallM,
    output logic [XLEN-1:0]     readdataM,
    output logic                doneM,
    output logic                misalign_excM,
    output logic                buserr_excM,
    output logic [1:0]          dbgState
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] waitCnt;
    logic [1:0]    offReg;
    logic [1:0]    widthReg;
    logic          sextReg;

    logic        op;
    logic        misaligned;
    logic [3:0]  stStrb;
    logic [31:0] stData;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] loadVal;

    assign op         = memwriteM | memtoregM;
    assign misaligned = (lswidthM == 2'b01 && aluoutM[0]) || (lswidthM[1] && aluoutM[1:0] != 2'b00);

    assign misalign_excM = (state == IDLE) && op && misaligned;
    assign stallM        = ((state == IDLE) && op && !misaligned) || (state == BUSY);
    assign doneM         = (state == DONE);
    assign dbgState      = state;

    always_comb begin
        stStrb = 4'b1111;
        stData = writedataM;
        if (lswidthM == 2'b00) begin
            stStrb = 4'b0001 << aluoutM[1:0];
            stData = {4{writedataM[7:0]}};
        end else if (lswidthM == 2'b01) begin
            stStrb = 4'b0011 << {aluoutM[1], 1'b0};
            stData = {2{writedataM[15:0]}};
        end
    end

    // Lane selection uses the offset captured at issue, not the live address.
    always_comb begin
        ldByte  = dbus.dbus_rdata[{offReg, 3'b000} +: 8];
        ldHalf  = dbus.dbus_rdata[{offReg[1], 4'b0000} +: 16];
        loadVal = dbus.dbus_rdata;
        if (widthReg == 2'b00)
            loadVal = {{24{ldByte[7] & sextReg}}, ldByte};
        else if (widthReg == 2'b01)
            loadVal = {{16{ldHalf[15] & sextReg}}, ldHalf};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wdata <= '0;
            dbus.dbus_wstrb <= 4'b0000;
            readdataM       <= '0;
            waitCnt         <= '0;
            buserr_excM     <= 1'b0;
            offReg          <= 2'b00;
            widthReg        <= 2'b00;
            sextReg         <= 1'b0;
        end else begin
            buserr_excM <= 1'b0;
            case (state)
                IDLE: begin
                    if (op && !misaligned) begin
                        dbus.dbus_req   <= 1'b1;
                        dbus.dbus_we    <= memwriteM;
                        dbus.dbus_addr  <= {aluoutM[XLEN-1:2], 2'b00};
                        dbus.dbus_wdata <= memwriteM ? stData : '0;
                        dbus.dbus_wstrb <= memwriteM ? stStrb : 4'b0000;
                        offReg          <= aluoutM[1:0];
                        widthReg        <= lswidthM;
                        sextReg         <= loadsignextM;
                        waitCnt         <= '0;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (dbus.dbus_ack) begin
                        if (!dbus.dbus_we) readdataM <= loadVal;
                        dbus.dbus_req <= 1'b0;
                        waitCnt       <= '0;
                        state         <= DONE;
                    end else if (TIMEOUT != 0 && waitCnt == TO_LAST) begin
                        buserr_excM   <= 1'b1;
                        dbus.dbus_req <= 1'b0;
                        waitCnt       <= '0;
                        state         <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu6_memstage_lsu.sv
// Directed bench for cpu6_memstage_lsu: driver tasks push expected bus requests and completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cpu6_memstage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        memwriteM, memtoregM, loadsignextM;
  logic [1:0]  lswidthM;
  logic [31:0] aluoutM, writedataM;
  logic        stallM, doneM, misalign_excM, buserr_excM;
  logic [31:0] readdataM;
  logic [1:0]  dbgState;

  cpu6_memstage_lsu_if #(.XLEN(32)) dbus ();

  cpu6_memstage_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .memwriteM(memwriteM), .memtoregM(memtoregM), .lswidthM(lswidthM),
    .loadsignextM(loadsignextM), .aluoutM(aluoutM), .writedataM(writedataM),
    .dbus(dbus.master),
    .stallM(stallM), .readdataM(readdataM), .doneM(doneM),
    .misalign_excM(misalign_excM), .buserr_excM(buserr_excM), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rd;

  // scoreboard queues: {is_store, we, addr, wdata, wstrb}, {buserr, readdata}, {stall, req}
  logic [69:0] req_q[$];
  logic [32:0] done_q[$];
  logic [1:0]  mis_q[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    logic [69:0] e;
    logic [32:0] d;
    logic [1:0]  m;
    if (!reset) begin
      if (dbus.dbus_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_req", 72'(dbus.dbus_addr), 72'hFFFF_FFFF_FFFF);
        else begin
          e = req_q.pop_front();
          if (e[69]) chk("req_store", 72'({dbus.dbus_we, dbus.dbus_addr, dbus.dbus_wdata, dbus.dbus_wstrb}), 72'(e[68:0]));
          else       chk("req_load", 72'({dbus.dbus_we, dbus.dbus_addr}), 72'(e[68:36]));
        end
      end
      if (doneM) begin
        if (done_q.size() == 0) chk("unexpected_done", 72'(readdataM), 72'hFFFF_FFFF_FFFF);
        else begin
          d = done_q.pop_front();
          chk("done_result", 72'({buserr_excM, readdataM}), 72'(d));
        end
      end
      if (misalign_excM) begin
        if (mis_q.size() == 0) chk("unexpected_misalign", 72'(aluoutM), 72'hFFFF_FFFF_FFFF);
        else begin
          m = mis_q.pop_front();
          chk("misalign_stall_req", 72'({stallM, dbus.dbus_req}), 72'(m));
        end
      end
      if (buserr_excM && !doneM) chk("buserr_outside_done", 72'(buserr_excM), 72'd0);
    end
    prev_req = dbus.dbus_req;
  end

  // driver tasks
  task automatic clear_in();
    memwriteM = 1'b0; memtoregM = 1'b0; lswidthM = 2'b00; loadsignextM = 1'b0;
    aluoutM = 32'h0; writedataM = 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion (or trap) cycle.
  task automatic do_op(input logic we, input logic rd, input logic [1:0] w, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int ack_at, input int exp_busy, input int exp_stall,
                       input logic [31:0] exp_addr, input logic [31:0] exp_wd, input logic [3:0] exp_st,
                       input logic [31:0] exp_rd, input logic is_mis);
    int stalls = 0;
    int busy_n = 0;
    bit seen = 0;
    logic [68:0] snap = '0;
    if (is_mis) mis_q.push_back(2'b00);
    else begin
      req_q.push_back({we, we, exp_addr, exp_wd, exp_st});
      done_q.push_back({(ack_at == 0), exp_rd});
      model_rd = exp_rd;
    end
    memwriteM = we; memtoregM = rd; lswidthM = w; loadsignextM = sx;
    aluoutM = a; writedataM = wd;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      dbus.dbus_ack = 1'b0;
      if (stallM) stalls++;
      if (dbus.dbus_req) begin
        busy_n++;
        if (busy_n == 1) snap = {dbus.dbus_we, dbus.dbus_addr, dbus.dbus_wdata, dbus.dbus_wstrb};
        else chk("bus_stable", 72'({dbus.dbus_we, dbus.dbus_addr, dbus.dbus_wdata, dbus.dbus_wstrb}), 72'(snap));
        if (busy_n == ack_at) begin
          dbus.dbus_ack = 1'b1;
          dbus.dbus_rdata = rdat;
        end
      end
      if (doneM || misalign_excM) seen = 1;
    end
    if (!seen) chk("op_timeout", 72'd0, 72'd1);
    chk("stall_cycles", 72'(stalls), 72'(exp_stall));
    chk("busy_cycles", 72'(busy_n), 72'(exp_busy));
    @(posedge clk); #1;
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_in();
    dbus.dbus_ack = 1'b0;
    dbus.dbus_rdata = 32'h0;
    model_rd = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 72'({dbus.dbus_req, dbus.dbus_we, dbus.dbus_addr, dbus.dbus_wdata, dbus.dbus_wstrb}), 72'd0);
    chk("reset_status", 72'({readdataM, stallM, doneM, misalign_excM, buserr_excM}), 72'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_status", 72'({dbus.dbus_req, readdataM, stallM, doneM, misalign_excM, buserr_excM}), 72'd0);
    @(posedge clk); #1;

    // load byte signed, ack in second BUSY cycle
    do_op(0, 1, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_FFFF, 2, 2, 3, 32'h1000, 32'h0, 4'h0, 32'hFFFF_FF80, 0);
    // store half upper lane
    do_op(1, 0, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h0, 1, 1, 2, 32'h2000, 32'hBEEF_BEEF, 4'b1100, 32'hFFFF_FF80, 0);
    // misaligned word load
    do_op(0, 1, 2'b10, 0, 32'h0006, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
    // store byte lane 1
    do_op(1, 0, 2'b00, 0, 32'h3001, 32'h1234_5678, 32'h0, 1, 1, 2, 32'h3000, 32'h7878_7878, 4'b0010, 32'hFFFF_FF80, 0);
    // load half signed upper
    do_op(0, 1, 2'b01, 1, 32'h4002, 32'h0, 32'h8001_7FFF, 1, 1, 2, 32'h4000, 32'h0, 4'h0, 32'hFFFF_8001, 0);
    // misaligned half load, misaligned half store
    do_op(0, 1, 2'b01, 0, 32'h4001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
    do_op(1, 0, 2'b01, 0, 32'h5003, 32'hFFFF, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
    // load byte unsigned at offset 3, ack in third BUSY cycle
    do_op(0, 1, 2'b00, 0, 32'h5003, 32'h0, 32'hAB00_0000, 3, 3, 4, 32'h5000, 32'h0, 4'h0, 32'h0000_00AB, 0);
    // width 11 behaves as word: aligned load, then misaligned
    do_op(0, 1, 2'b11, 1, 32'h6000, 32'h0, 32'hDEAD_BEEF, 1, 1, 2, 32'h6000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    do_op(0, 1, 2'b11, 0, 32'h6002, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 1);
    // memwrite and memtoreg together -> store
    do_op(1, 1, 2'b10, 0, 32'h7004, 32'hCAFE_F00D, 32'h0, 1, 1, 2, 32'h7004, 32'hCAFE_F00D, 4'b1111, 32'hDEAD_BEEF, 0);
    // store with no ack: bus timeout after 4 BUSY cycles
    do_op(1, 0, 2'b10, 0, 32'h8000, 32'h1111_2222, 32'h0, 0, 4, 5, 32'h8000, 32'h1111_2222, 4'b1111, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("idle_after_timeout", 72'({dbgState, stallM, doneM, buserr_excM, dbus.dbus_req}), 72'd0);
    @(posedge clk); #1;
    // back-to-back: load half unsigned then store byte
    do_op(0, 1, 2'b01, 0, 32'h0010, 32'h0, 32'h1234_F00D, 1, 1, 2, 32'h0010, 32'h0, 4'h0, 32'h0000_F00D, 0);
    do_op(1, 0, 2'b00, 0, 32'h0012, 32'h0000_00A5, 32'h0, 1, 1, 2, 32'h0010, 32'hA5A5_A5A5, 4'b0100, 32'h0000_F00D, 0);

    // stray ack while idle is ignored
    @(negedge clk);
    dbus.dbus_ack = 1'b1;
    dbus.dbus_rdata = 32'h5555_5555;
    @(negedge clk);
    dbus.dbus_ack = 1'b0;
    chk("stray_ack", 72'({readdataM, doneM, dbus.dbus_req}), 72'({model_rd, 2'b00}));

    // reset in BUSY, late ack ignored
    @(posedge clk); #1;
    req_q.push_back({1'b0, 1'b0, 32'h9000, 32'h0, 4'h0});
    memtoregM = 1'b1; lswidthM = 2'b10; aluoutM = 32'h9000;
    begin
      bit got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (dbus.dbus_req) got = 1;
      end
      if (!got) chk("reset_test_req_timeout", 72'd0, 72'd1);
    end
    #2;
    reset = 1'b1;
    clear_in();
    #1;
    chk("async_reset_req", 72'({dbus.dbus_req, readdataM, dbgState}), 72'd0);
    @(negedge clk);
    reset = 1'b0;
    dbus.dbus_ack = 1'b1;
    dbus.dbus_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dbus.dbus_ack = 1'b0;
      chk("late_ack_ignored", 72'({doneM, dbus.dbus_req, readdataM, stallM}), 72'd0);
    end

    chk("req_q_empty", 72'(req_q.size()), 72'd0);
    chk("done_q_empty", 72'(done_q.size()), 72'd0);
    chk("mis_q_empty", 72'(mis_q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu6_memstage_lsu.md
CPU6_MEMSTAGE_LSU -- requirements
Module: cpu6_memstage_lsu

Interface
REQ-001 Parameter XLEN, 32, data/address width; only 32 is supported.
REQ-002 Parameter TIMEOUT, 255, maximum BUSY cycles waiting for dbus_ack (0 = no timeout).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 memwriteM  in  1  store request from the EX/MEM register.
REQ-007 memtoregM  in  1  load request from the EX/MEM register.
REQ-008 lswidthM  in  2  access width: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 loadsignextM  in  1  1 = sign-extend load result, 0 = zero-extend.
REQ-010 aluoutM  in  XLEN  effective byte address.
REQ-011 writedataM  in  XLEN  store data, right-justified.
REQ-012 dbus_req  out  1  bus request, registered.
REQ-013 dbus_we  out  1  1 = write, registered.
REQ-014 dbus_addr  out  XLEN  word address {aluoutM[31:2],2'b00}, registered.
REQ-015 dbus_wdata  out  XLEN  lane-replicated store data, registered.
REQ-016 dbus_wstrb  out  4  byte enables, registered.
REQ-017 dbus_ack  in  1  one-cycle completion strobe from the bus.
REQ-018 dbus_rdata  in  XLEN  read data, valid in the dbus_ack cycle of a read.
REQ-019 stallM  out  1  freeze IF..MEM pipeline registers.
REQ-020 readdataM  out  XLEN  aligned, extended load result.
REQ-021 doneM  out  1  access complete; readdataM valid this cycle.
REQ-022 misalign_excM  out  1  misaligned-access exception pulse.
REQ-023 buserr_excM  out  1  bus timeout exception pulse.

Function
REQ-024 op = memwriteM | memtoregM; if both are asserted, the op SHALL be a store.
REQ-025 Misaligned: half with aluoutM[0]=1, or word with aluoutM[1:0]!=00; byte is never misaligned.
REQ-026 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-027 IDLE, op and misaligned: misalign_excM=1 (combinational), stallM=0, no bus request, stay IDLE.
REQ-028 IDLE, op and aligned: stallM=1 (combinational); at the next edge load the dbus_* registers with dbus_req=1 and go BUSY.
REQ-029 BUSY: stallM=1; dbus_req and all dbus_* outputs SHALL stay constant until the dbus_ack cycle.
REQ-030 BUSY with dbus_ack: capture the read result into readdataM (stores leave it unchanged), clear dbus_req, clear the wait counter, go DONE.
REQ-031 DONE: stallM=0, doneM=1 for exactly one cycle, then go IDLE unconditionally; the same instruction SHALL NOT be reissued.
REQ-032 Wait counter: counts BUSY cycles without ack; when TIMEOUT!=0 and the count reaches TIMEOUT, assert buserr_excM for one cycle, clear dbus_req, and go DONE.
REQ-033 Store strobes: byte 0001<<a[1:0]; half 0011<<{a[1],0}; word 1111.
REQ-034 Store data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
REQ-035 Load data: byte rdata[8*a[1:0]+:8]; half rdata[16*a[1]+:16]; word rdata; extended to 32 bits per loadsignextM.
REQ-036 dbus_ack outside BUSY SHALL be ignored.

Reset
REQ-037 Reset SHALL force IDLE immediately (asynchronous): dbus_req=0, dbus_we=0, dbus_addr=0, dbus_wdata=0, dbus_wstrb=0, readdataM=0, wait counter=0.
REQ-038 With no op in IDLE, stallM, doneM, misalign_excM and buserr_excM are 0 under reset and after it.
REQ-039 Reset mid-BUSY SHALL drop dbus_req asynchronously, and a late dbus_ack SHALL be ignored.

Verification
REQ-040 Load byte signed, a=0x1003, rdata=0x80FFFFFF, ack two cycles after req -> readdataM=0xFFFFFF80, doneM for 1 cycle, stallM high for 3 cycles.
REQ-041 Store half, a=0x2002, wd=0x0000BEEF -> dbus_we=1, addr=0x2000, wstrb=1100, wdata=0xBEEFBEEF.
REQ-042 Load word, a=0x0006 -> misalign_excM=1 for one cycle, dbus_req never asserted, stallM=0.
REQ-043 TIMEOUT=4, store with no ack -> buserr_excM after 4 BUSY cycles, then DONE, then IDLE.
REQ-044 Reset asserted in BUSY, ack arrives the following cycle -> dbus_req=0 immediately, doneM stays 0.
REQ-045 Load half unsigned, a=0x10, rdata=0x1234F00D, ack in first BUSY cycle, followed back-to-back by a store byte -> readdataM=0x0000F00D, then a new request with wstrb per REQ-033.
